// File: rtl/biu_gen.sv
// Bus interface unit: runs one command as up to two req/ack phases against the
// GPR file and the RAM/ROM port, with per-phase ack timeout and a response pulse.
module biu_gen #(
    parameter int DW     = 16,
    parameter int AW     = 16,
    parameter int RW     = 3,
    parameter int TO_CYC = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [RW-1:0] cmd_rd,
    input  logic [RW-1:0] cmd_rs,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_imm,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_err,
    output logic          gpr_req,
    output logic          gpr_we,
    output logic [RW-1:0] gpr_idx,
    output logic [DW-1:0] gpr_wdata,
    input  logic [DW-1:0] gpr_rdata,
    input  logic          gpr_ack,
    output logic          mem_req,
    output logic          mem_we,
    output logic          mem_rom,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack
);

    typedef enum logic [2:0] {
        S_IDLE, S_GRD, S_GWR, S_MRD, S_MWR, S_RESP
    } state_t;

    localparam logic [2:0] OP_MOVR  = 3'd0;
    localparam logic [2:0] OP_MOVI  = 3'd1;
    localparam logic [2:0] OP_LOAD  = 3'd2;
    localparam logic [2:0] OP_STORE = 3'd3;
    localparam logic [2:0] OP_FETCH = 3'd4;
    localparam logic [2:0] OP_RDREG = 3'd5;

    localparam int CW = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'((TO_CYC > 0) ? TO_CYC - 1 : 0);

    state_t        r_state, w_next;
    logic [2:0]    r_op;
    logic [RW-1:0] r_rd, r_rs;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_imm, r_rdata;
    logic [CW-1:0] r_cnt;
    logic          r_err;
    logic          r_gpr_req, r_gpr_we, r_mem_req, r_mem_we, r_mem_rom;
    logic [RW-1:0] r_gpr_idx;
    logic [DW-1:0] r_gpr_wdata, r_mem_wdata;
    logic [AW-1:0] r_mem_addr;

    logic          w_accept, w_ack, w_to;
    logic [2:0]    w_op;
    logic [RW-1:0] w_rd, w_rs;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_imm, w_rdata_nxt;

    assign w_accept = (r_state == S_IDLE) && cmd_valid;
    // Fields come straight from the command port on the accept edge.
    assign w_op   = (r_state == S_IDLE) ? cmd_op   : r_op;
    assign w_rd   = (r_state == S_IDLE) ? cmd_rd   : r_rd;
    assign w_rs   = (r_state == S_IDLE) ? cmd_rs   : r_rs;
    assign w_addr = (r_state == S_IDLE) ? cmd_addr : r_addr;
    assign w_imm  = (r_state == S_IDLE) ? cmd_imm  : r_imm;

    assign w_ack = (r_gpr_req && gpr_ack) || (r_mem_req && mem_ack);
    assign w_to  = (TO_CYC != 0) && (r_gpr_req || r_mem_req)
                   && !w_ack && (r_cnt == TO_LAST);

    always_comb begin
        w_rdata_nxt = r_rdata;
        if (r_state == S_GRD && gpr_ack)
            w_rdata_nxt = gpr_rdata;
        else if (r_state == S_MRD && mem_ack)
            w_rdata_nxt = mem_rdata;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (cmd_valid) begin
                unique case (cmd_op)
                    OP_MOVR, OP_STORE, OP_RDREG: w_next = S_GRD;
                    OP_MOVI:                     w_next = S_GWR;
                    OP_LOAD, OP_FETCH:           w_next = S_MRD;
                    default:                     w_next = S_RESP;
                endcase
            end
            S_GRD: begin
                if (w_ack) begin
                    if (r_op == OP_MOVR)       w_next = S_GWR;
                    else if (r_op == OP_STORE) w_next = S_MWR;
                    else                       w_next = S_RESP;
                end else if (w_to) begin
                    w_next = S_RESP;
                end
            end
            S_MRD: begin
                if (w_ack)
                    w_next = (r_op == OP_LOAD) ? S_GWR : S_RESP;
                else if (w_to)
                    w_next = S_RESP;
            end
            S_GWR, S_MWR: if (w_ack || w_to) w_next = S_RESP;
            S_RESP: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_op        <= '0;
            r_rd        <= '0;
            r_rs        <= '0;
            r_addr      <= '0;
            r_imm       <= '0;
            r_rdata     <= '0;
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_gpr_req   <= 1'b0;
            r_gpr_we    <= 1'b0;
            r_gpr_idx   <= '0;
            r_gpr_wdata <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_rom   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_op    <= cmd_op;
                r_rd    <= cmd_rd;
                r_rs    <= cmd_rs;
                r_addr  <= cmd_addr;
                r_imm   <= cmd_imm;
                r_rdata <= '0;
                r_err   <= (w_next == S_RESP);
            end else begin
                r_rdata <= w_rdata_nxt;
                if (w_to) r_err <= 1'b1;
            end
            // Counter restarts on every state change, so each phase gets its own budget.
            r_cnt <= (w_next != r_state) ? '0 : r_cnt + 1'b1;
            r_gpr_req   <= (w_next == S_GRD) || (w_next == S_GWR);
            r_gpr_we    <= (w_next == S_GWR);
            r_gpr_idx   <= (w_next == S_GRD) ? w_rs :
                           (w_next == S_GWR) ? w_rd : '0;
            r_gpr_wdata <= (w_next != S_GWR) ? '0 :
                           (w_op == OP_MOVI) ? w_imm : w_rdata_nxt;
            r_mem_req   <= (w_next == S_MRD) || (w_next == S_MWR);
            r_mem_we    <= (w_next == S_MWR);
            r_mem_rom   <= (w_next == S_MRD) && (w_op == OP_FETCH);
            r_mem_addr  <= ((w_next == S_MRD) || (w_next == S_MWR)) ? w_addr : '0;
            r_mem_wdata <= (w_next == S_MWR) ? w_rdata_nxt : '0;
        end
    end

    assign cmd_ready = (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_err   = (r_state == S_RESP) && r_err;
    assign rsp_data  = ((r_state == S_RESP) && !r_err &&
                        (r_op == OP_MOVR || r_op == OP_LOAD ||
                         r_op == OP_FETCH || r_op == OP_RDREG)) ? r_rdata : '0;

    assign gpr_req   = r_gpr_req;
    assign gpr_we    = r_gpr_we;
    assign gpr_idx   = r_gpr_idx;
    assign gpr_wdata = r_gpr_wdata;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_rom   = r_mem_rom;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_biu_gen.sv
// Directed bench for biu_gen: op sequences, wait states, timeout, illegal op,
// back-to-back commands and asynchronous reset mid-phase.
module tb_biu_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [2:0]  cmd_rd, cmd_rs;
    logic [15:0] cmd_addr, cmd_imm;
    logic        rsp_valid, rsp_err;
    logic [15:0] rsp_data;
    logic        gpr_req, gpr_we, gpr_ack;
    logic [2:0]  gpr_idx;
    logic [15:0] gpr_wdata, gpr_rdata;
    logic        mem_req, mem_we, mem_rom, mem_ack;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    biu_gen #(.DW(16), .AW(16), .RW(3), .TO_CYC(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_rd(cmd_rd), .cmd_rs(cmd_rs), .cmd_addr(cmd_addr), .cmd_imm(cmd_imm),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .gpr_req(gpr_req), .gpr_we(gpr_we), .gpr_idx(gpr_idx),
        .gpr_wdata(gpr_wdata), .gpr_rdata(gpr_rdata), .gpr_ack(gpr_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_rom(mem_rom),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a command at posedge+1, returns in window 1 after the accept edge.
    task automatic issue(input logic [2:0] op, input logic [2:0] rd,
                         input logic [2:0] rs, input logic [15:0] addr,
                         input logic [15:0] imm);
        cmd_op = op; cmd_rd = rd; cmd_rs = rs; cmd_addr = addr; cmd_imm = imm;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready got=%b exp=1", cmd_ready);
        end
        n_cmp++;
        if ({rsp_valid, rsp_err, gpr_req, mem_req, gpr_we, mem_we} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_outs got=%b exp=000000",
                     {rsp_valid, rsp_err, gpr_req, mem_req, gpr_we, mem_we});
        end
        n_cmp++;
        if (rsp_data !== 16'h0 || mem_addr !== 16'h0) begin
            n_fail++; $display("FAIL reset_data got=%h/%h exp=0", rsp_data, mem_addr);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_mov_reg();
        gpr_ack = 1'b1; gpr_rdata = 16'h1234;
        issue(3'd0, 3'd5, 3'd2, 16'h0, 16'h0);
        n_cmp++;
        if ({gpr_req, gpr_we, gpr_idx, mem_req} !== {1'b1, 1'b0, 3'd2, 1'b0}) begin
            n_fail++;
            $display("FAIL movr_grd got req=%b we=%b idx=%0d", gpr_req, gpr_we, gpr_idx);
        end
        step();
        n_cmp++;
        if ({gpr_req, gpr_we, gpr_idx, gpr_wdata} !== {1'b1, 1'b1, 3'd5, 16'h1234}) begin
            n_fail++;
            $display("FAIL movr_gwr got req=%b we=%b idx=%0d wd=%h",
                     gpr_req, gpr_we, gpr_idx, gpr_wdata);
        end
        step();
        n_cmp++;
        if ({rsp_valid, rsp_err, rsp_data, cmd_ready} !== {1'b1, 1'b0, 16'h1234, 1'b0}) begin
            n_fail++;
            $display("FAIL movr_rsp got v=%b e=%b d=%h rdy=%b",
                     rsp_valid, rsp_err, rsp_data, cmd_ready);
        end
        step();
        n_cmp++;
        if ({rsp_valid, cmd_ready, gpr_req} !== 3'b010) begin
            n_fail++;
            $display("FAIL movr_idle got v=%b rdy=%b req=%b", rsp_valid, cmd_ready, gpr_req);
        end
    endtask

    task automatic test_load_wait();
        int req_cyc = 0;
        int bad = 0;
        gpr_ack = 1'b1; mem_ack = 1'b0; mem_rdata = 16'hBEEF;
        issue(3'd2, 3'd1, 3'd0, 16'h0040, 16'h0);
        for (int w = 1; w <= 5; w++) begin
            if (mem_req) req_cyc++;
            if (mem_addr !== 16'h0040 || mem_rom !== 1'b0 || mem_we !== 1'b0 || gpr_req !== 1'b0)
                bad++;
            if (w == 5) mem_ack = 1'b1;
            step();
            mem_ack = 1'b0;
        end
        n_cmp++;
        if (req_cyc !== 5 || bad !== 0) begin
            n_fail++; $display("FAIL load_mrd got req_cyc=%0d bad=%0d exp=5/0", req_cyc, bad);
        end
        n_cmp++;
        if ({mem_req, gpr_req, gpr_we, gpr_idx, gpr_wdata} !==
            {1'b0, 1'b1, 1'b1, 3'd1, 16'hBEEF}) begin
            n_fail++;
            $display("FAIL load_gwr got mreq=%b req=%b we=%b idx=%0d wd=%h",
                     mem_req, gpr_req, gpr_we, gpr_idx, gpr_wdata);
        end
        step();
        n_cmp++;
        if ({rsp_valid, rsp_err, rsp_data} !== {1'b1, 1'b0, 16'hBEEF}) begin
            n_fail++;
            $display("FAIL load_rsp_w7 got v=%b e=%b d=%h", rsp_valid, rsp_err, rsp_data);
        end
        step();
    endtask

    // With ack_win=0 the ack never comes; otherwise it arrives in that window.
    task automatic run_fetch(input int ack_win, output int req_cyc, output int gpr_seen,
                             output int rom_bad, output int rsp_w,
                             output logic err, output logic [15:0] data);
        req_cyc = 0; gpr_seen = 0; rom_bad = 0; rsp_w = 0; err = 1'b0; data = '0;
        mem_ack = 1'b0; mem_rdata = 16'hCAFE;
        issue(3'd4, 3'd0, 3'd0, 16'h0100, 16'h0);
        for (int w = 1; w <= 20; w++) begin
            if (rsp_valid) begin
                rsp_w = w; err = rsp_err; data = rsp_data;
                break;
            end
            if (mem_req) begin
                req_cyc++;
                if (mem_rom !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h0100) rom_bad++;
            end
            if (gpr_req) gpr_seen++;
            if (w == ack_win) mem_ack = 1'b1;
            step();
            mem_ack = 1'b0;
        end
        step();
    endtask

    task automatic test_fetch_timeout();
        int rc, gs, rb, rw;
        logic e;
        logic [15:0] d;
        run_fetch(0, rc, gs, rb, rw, e, d);
        n_cmp++;
        if (rc !== 8 || rb !== 0) begin
            n_fail++; $display("FAIL fetch_to_req got cyc=%0d bad=%0d exp=8/0", rc, rb);
        end
        n_cmp++;
        if (gs !== 0) begin
            n_fail++; $display("FAIL fetch_to_gpr got=%0d exp=0", gs);
        end
        n_cmp++;
        if (rw !== 9 || e !== 1'b1 || d !== 16'h0) begin
            n_fail++; $display("FAIL fetch_to_rsp got w=%0d e=%b d=%h exp=9/1/0", rw, e, d);
        end
    endtask

    task automatic test_ack_vs_timeout();
        int rc, gs, rb, rw;
        logic e;
        logic [15:0] d;
        run_fetch(8, rc, gs, rb, rw, e, d);
        n_cmp++;
        if (rw !== 9 || e !== 1'b0 || d !== 16'hCAFE || rc !== 8) begin
            n_fail++;
            $display("FAIL fetch_ack_last got w=%0d e=%b d=%h cyc=%0d exp=9/0/cafe/8",
                     rw, e, d, rc);
        end
    endtask

    task automatic test_store();
        gpr_ack = 1'b1; mem_ack = 1'b1; gpr_rdata = 16'h00AA;
        issue(3'd3, 3'd0, 3'd3, 16'h0010, 16'h0);
        n_cmp++;
        if ({gpr_req, gpr_we, gpr_idx, mem_req} !== {1'b1, 1'b0, 3'd3, 1'b0}) begin
            n_fail++;
            $display("FAIL store_grd got req=%b we=%b idx=%0d", gpr_req, gpr_we, gpr_idx);
        end
        step();
        n_cmp++;
        if ({mem_req, mem_we, mem_rom, mem_addr, mem_wdata, gpr_req} !==
            {1'b1, 1'b1, 1'b0, 16'h0010, 16'h00AA, 1'b0}) begin
            n_fail++;
            $display("FAIL store_mwr got req=%b we=%b rom=%b a=%h wd=%h",
                     mem_req, mem_we, mem_rom, mem_addr, mem_wdata);
        end
        step();
        n_cmp++;
        if ({rsp_valid, rsp_err, rsp_data} !== {1'b1, 1'b0, 16'h0}) begin
            n_fail++;
            $display("FAIL store_rsp got v=%b e=%b d=%h", rsp_valid, rsp_err, rsp_data);
        end
        mem_ack = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        gpr_ack = 1'b1;
        cmd_op = 3'd7; cmd_rd = 3'd0; cmd_rs = 3'd0; cmd_addr = '0; cmd_imm = '0;
        cmd_valid = 1'b1;
        step();
        cmd_op = 3'd1; cmd_rd = 3'd6; cmd_imm = 16'h7777;
        n_cmp++;
        if ({rsp_valid, rsp_err, rsp_data, gpr_req, mem_req, cmd_ready} !==
            {1'b1, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL illegal_rsp got v=%b e=%b d=%h g=%b m=%b rdy=%b",
                     rsp_valid, rsp_err, rsp_data, gpr_req, mem_req, cmd_ready);
        end
        step();
        n_cmp++;
        if ({cmd_ready, gpr_req, rsp_valid} !== 3'b100) begin
            n_fail++;
            $display("FAIL b2b_held got rdy=%b req=%b v=%b exp=100",
                     cmd_ready, gpr_req, rsp_valid);
        end
        step();
        cmd_valid = 1'b0;
        n_cmp++;
        if ({gpr_req, gpr_we, gpr_idx, gpr_wdata} !== {1'b1, 1'b1, 3'd6, 16'h7777}) begin
            n_fail++;
            $display("FAIL b2b_movi got req=%b we=%b idx=%0d wd=%h",
                     gpr_req, gpr_we, gpr_idx, gpr_wdata);
        end
        step();
        n_cmp++;
        if ({rsp_valid, rsp_err, rsp_data} !== {1'b1, 1'b0, 16'h0}) begin
            n_fail++;
            $display("FAIL b2b_rsp got v=%b e=%b d=%h", rsp_valid, rsp_err, rsp_data);
        end
        step();
    endtask

    task automatic test_reset_mid_phase();
        int seen = 0;
        gpr_ack = 1'b0;
        issue(3'd1, 3'd4, 3'd0, 16'h0, 16'h5A5A);
        step();
        n_cmp++;
        if (gpr_req !== 1'b1 || gpr_we !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_pre got req=%b we=%b exp=1/1", gpr_req, gpr_we);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (gpr_req !== 1'b0 || gpr_we !== 1'b0 || gpr_wdata !== 16'h0) begin
            n_fail++;
            $display("FAIL rstmid_drop got req=%b we=%b wd=%h", gpr_req, gpr_we, gpr_wdata);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            if (rsp_valid) seen++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (rsp_valid) seen++;
        end
        n_cmp++;
        if (seen !== 0 || cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_idle got rsp=%0d rdy=%b exp=0/1", seen, cmd_ready);
        end
        gpr_ack = 1'b1;
        issue(3'd1, 3'd2, 3'd0, 16'h0, 16'h0F0F);
        n_cmp++;
        if ({gpr_req, gpr_we, gpr_idx, gpr_wdata} !== {1'b1, 1'b1, 3'd2, 16'h0F0F}) begin
            n_fail++;
            $display("FAIL rstmid_movi got req=%b we=%b idx=%0d wd=%h",
                     gpr_req, gpr_we, gpr_idx, gpr_wdata);
        end
        step();
        n_cmp++;
        if ({rsp_valid, rsp_err, rsp_data} !== {1'b1, 1'b0, 16'h0}) begin
            n_fail++;
            $display("FAIL rstmid_rsp got v=%b e=%b d=%h", rsp_valid, rsp_err, rsp_data);
        end
        step();
    endtask

    initial begin
        cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_rs = '0;
        cmd_addr = '0; cmd_imm = '0;
        gpr_ack = 1'b0; gpr_rdata = '0; mem_ack = 1'b0; mem_rdata = '0;
        test_reset();
        test_mov_reg();
        test_load_wait();
        test_fetch_timeout();
        test_ack_vs_timeout();
        test_store();
        test_back_to_back();
        test_reset_mid_phase();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/biu_gen.md
Name: biu_gen

Overview:
Parametrised bus interface unit that sequences register-file and memory transfers for the execution and fetch logic. It accepts one command at a time over a valid/ready port and runs it as one or two bus phases against the GPR file and the RAM/ROM memory port, using explicit req/ack handshakes instead of a shared tristate bus. It adds a wait-state timeout with error reporting and a single-cycle response channel.

Parameters:
DW, 16, data width of GPR and memory buses
AW, 16, memory address width
RW, 3, GPR index width (2**RW registers)
TO_CYC, 16, max cycles a phase waits for ack before abort; 0 disables timeout

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  high only in IDLE
cmd_op  in  3  0 MOV_REG, 1 MOV_IMM, 2 LOAD, 3 STORE, 4 FETCH, 5 RDREG, 6-7 illegal
cmd_rd  in  RW  destination register
cmd_rs  in  RW  source register
cmd_addr  in  AW  memory/ROM address
cmd_imm  in  DW  immediate
rsp_valid  out  1  one-cycle completion pulse
rsp_data  out  DW  read data (FETCH, RDREG, LOAD, MOV_REG), else 0
rsp_err  out  1  valid with rsp_valid: timeout or illegal op
gpr_req  out  1  GPR phase request
gpr_we  out  1  1 write, 0 read
gpr_idx  out  RW  register index
gpr_wdata  out  DW  write data
gpr_rdata  in  DW  read data, sampled on ack
gpr_ack  in  1  phase complete
mem_req  out  1  memory phase request
mem_we  out  1  1 write (RAM only)
mem_rom  out  1  1 selects ROM, 0 RAM
mem_addr  out  AW  address
mem_wdata  out  DW  write data
mem_rdata  in  DW  read data, sampled on ack
mem_ack  in  1  phase complete

Behaviour:
- Reset (rst_n low, async): state IDLE; all outputs 0 except cmd_ready=1; timeout counter and captured data cleared. Reset mid-phase drops req immediately; no response issued.
- Accept: edge where cmd_valid & cmd_ready; all cmd_* fields latched; cmd_ready low until return to IDLE.
- States: IDLE, GRD (gpr read), GWR (gpr write), MRD (mem read), MWR (mem write), RESP.
- Op sequences: MOV_REG GRD(rs)->GWR(rd, data=read); MOV_IMM GWR(rd, imm); LOAD MRD(RAM, addr)->GWR(rd, data=read); STORE GRD(rs)->MWR(RAM, addr, data=read); FETCH MRD(ROM, addr); RDREG GRD(rs). Every sequence ends in RESP.
- Illegal op: IDLE->RESP directly, rsp_err=1, rsp_data=0, no bus phase.
- Handshake: req, we, idx/addr, wdata are registered, asserted from the first cycle in the phase state and held stable until the edge where ack=1 is sampled. Read data captured on that edge. Next state entered at that edge. Ack is ignored when req is low.
- Latency: with ack tied high, single-phase op gives rsp_valid 2 cycles after accept edge; two-phase op gives 3. Each wait cycle adds 1.
- Timeout: counter reset on phase entry, +1 per cycle without ack. When count reaches TO_CYC-1 with no ack, the phase is abandoned at that edge: req drops, remaining phases skipped, RESP with rsp_err=1, rsp_data=0. Ack and timeout in the same cycle: ack wins.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE with cmd_ready=1. No backpressure on the response. rsp_data holds the last captured read (GRD/MRD) for MOV_REG, LOAD, FETCH, RDREG, and 0 otherwise.
- gpr_req and mem_req are never high together. STORE and LOAD never touch ROM. FETCH never writes.

Test Plan:
- MOV_REG rs=2 rd=5, gpr_ack tied 1, gpr_rdata=16'h1234 -> GRD idx 2 then GWR idx 5 wdata 16'h1234; rsp_valid 3 cycles after accept, rsp_data=16'h1234, err=0.
- LOAD addr=16'h0040 rd=1, mem_ack delayed 4 cycles, mem_rdata=16'hBEEF -> mem_req held 5 cycles with addr stable, mem_rom=0; then GWR idx 1 data 16'hBEEF; rsp_valid at cycle 7 after accept.
- FETCH addr=16'h0100, TO_CYC=8, mem_ack never -> mem_rom=1, req high 8 cycles then drops; rsp_valid with rsp_err=1, rsp_data=0; no gpr_req.
- STORE rs=3 addr=16'h0010, gpr_rdata=16'h00AA -> MWR with mem_we=1, wdata 16'h00AA, mem_rom=0; rsp_data=0.
- cmd_op=7 -> rsp_valid 1 cycle after accept, rsp_err=1, no req asserted. Back-to-back cmd_valid is accepted only after RESP.
- rst_n low during GWR wait -> gpr_req=0 asynchronously, no rsp_valid; after release, cmd_ready=1 and the next MOV_IMM completes normally.
